// File: rtl/ifetch_unit.sv
// Instruction fetch unit: reads one instruction word per request, hands it to the IR
// with a one-cycle load strobe, and owns the program counter including redirects.
module ifetch_unit #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_val,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] ir_d,
   output logic              ir_ce,
   output logic              fetch_done,
   output logic              fetch_err,
   output logic              busy,
   output logic [ADDR_W-1:0] pc_out
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] LOAD = 2'd2;

   logic [1:0]        state_q, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              rd_q, rd_nxt;
   logic [DATA_W-1:0] ir_q, ir_nxt;
   logic              ce_q, ce_nxt;
   logic              done_q, done_nxt;
   logic              err_q, err_nxt;
   logic              busy_q, busy_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic              pend_q, pend_nxt;
   logic [ADDR_W-1:0] pend_val_q, pend_val_nxt;
   logic [ADDR_W-1:0] exit_pc;

   // PC on leaving a busy state: a redirect this cycle beats an older pending one
   always_comb begin
      exit_pc = pc_q;
      if (pc_load)     exit_pc = pc_load_val;
      else if (pend_q) exit_pc = pend_val_q;
   end

   always_comb begin
      state_nxt    = state_q;
      pc_nxt       = pc_q;
      addr_nxt     = addr_q;
      rd_nxt       = rd_q;
      ir_nxt       = ir_q;
      ce_nxt       = 1'b0;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
      cnt_nxt      = cnt_q;
      pend_nxt     = pend_q;
      pend_val_nxt = pend_val_q;

      case (state_q)
         IDLE: begin
            if (fetch_req) begin
               addr_nxt  = pc_load ? pc_load_val : pc_q;
               rd_nxt    = 1'b1;
               cnt_nxt   = '0;
               pend_nxt  = 1'b0;
               state_nxt = WAIT;
            end
            if (pc_load) pc_nxt = pc_load_val;
         end
         WAIT: begin
            if (pc_load) begin
               pend_nxt     = 1'b1;
               pend_val_nxt = pc_load_val;
            end
            // Ack wins over a timeout falling on the same cycle
            if (mem_ack) begin
               ir_nxt    = mem_rdata;
               rd_nxt    = 1'b0;
               ce_nxt    = 1'b1;
               done_nxt  = 1'b1;
               pc_nxt    = addr_q + ADDR_W'(1);
               state_nxt = LOAD;
            end else if (cnt_q == CNT_LAST) begin
               rd_nxt    = 1'b0;
               err_nxt   = 1'b1;
               pc_nxt    = exit_pc;
               pend_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         LOAD: begin
            pc_nxt    = exit_pc;
            pend_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= ADDR_W'(RESET_PC);
         addr_q     <= '0;
         rd_q       <= 1'b0;
         ir_q       <= '0;
         ce_q       <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
      end else begin
         state_q    <= state_nxt;
         pc_q       <= pc_nxt;
         addr_q     <= addr_nxt;
         rd_q       <= rd_nxt;
         ir_q       <= ir_nxt;
         ce_q       <= ce_nxt;
         done_q     <= done_nxt;
         err_q      <= err_nxt;
         busy_q     <= busy_nxt;
         cnt_q      <= cnt_nxt;
         pend_q     <= pend_nxt;
         pend_val_q <= pend_val_nxt;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_rd     = rd_q;
   assign ir_d       = ir_q;
   assign ir_ce      = ce_q;
   assign fetch_done = done_q;
   assign fetch_err  = err_q;
   assign busy       = busy_q;
   assign pc_out     = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: transaction-level reference model checked every cycle,
// plus literal expectations on the key points of each scenario.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic        pc_load = 1'b0;
   logic [15:0] pc_load_val = '0;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [15:0] ir_d;
   logic        ir_ce;
   logic        fetch_done;
   logic        fetch_err;
   logic        busy;
   logic [15:0] pc_out;

   int vectors = 0;
   int errs    = 0;
   bit cmp_en  = 1'b0;

   ifetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(0), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load),
      .pc_load_val(pc_load_val), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir_d(ir_d), .ir_ce(ir_ce),
      .fetch_done(fetch_done), .fetch_err(fetch_err), .busy(busy), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   // Reference model: a fetch is "in flight" until acked or until 15 unacked wait cycles pass
   localparam int TMO = 15;
   int          m_phase;    // 0 idle, 1 request outstanding, 2 word just delivered
   int          m_waited;
   logic [15:0] m_pc, m_addr, m_ir;
   logic        m_rd, m_ce, m_err;
   logic [15:0] m_redir[$];

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_waited = 0; m_pc = 16'h0000; m_addr = 16'h0000; m_ir = 16'h0000;
         m_rd = 1'b0; m_ce = 1'b0; m_err = 1'b0; m_redir.delete();
      end else begin
         m_ce  = 1'b0;
         m_err = 1'b0;
         if (m_phase == 0) begin
            if (fetch_req) begin
               m_addr = pc_load ? pc_load_val : m_pc;
               m_rd = 1'b1; m_waited = 0; m_phase = 1; m_redir.delete();
            end
            if (pc_load) m_pc = pc_load_val;
         end else if (m_phase == 1) begin
            if (pc_load) m_redir.push_back(pc_load_val);
            if (mem_ack) begin
               m_ir = mem_rdata; m_rd = 1'b0; m_ce = 1'b1;
               m_pc = m_addr + 16'd1; m_phase = 2;
            end else begin
               m_waited++;
               if (m_waited == TMO) begin
                  m_rd = 1'b0; m_err = 1'b1; m_phase = 0;
                  if (m_redir.size() > 0) m_pc = m_redir[$];
                  m_redir.delete();
               end
            end
         end else begin
            if (pc_load) m_redir.push_back(pc_load_val);
            if (m_redir.size() > 0) m_pc = m_redir[$];
            m_redir.delete();
            m_phase = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mem_addr",   32'(mem_addr),   32'(m_addr));
         chk("mem_rd",     32'(mem_rd),     32'(m_rd));
         chk("ir_d",       32'(ir_d),       32'(m_ir));
         chk("ir_ce",      32'(ir_ce),      32'(m_ce));
         chk("fetch_done", 32'(fetch_done), 32'(m_ce));
         chk("fetch_err",  32'(fetch_err),  32'(m_err));
         chk("busy",       32'(busy),       32'(m_phase != 0));
         chk("pc_out",     32'(pc_out),     32'(m_pc));
      end
   end

   task automatic cyc(input logic r, input logic f, input logic pl, input logic [15:0] plv,
                      input logic a, input logic [15:0] rd);
      @(negedge clk);
      rst = r; fetch_req = f; pc_load = pl; pc_load_val = plv; mem_ack = a; mem_rdata = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
   endtask

   initial begin
      // Reset, then a single fetch acked two cycles after the request
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      cmp_en = 1'b1;
      chk("rst_pc", 32'(pc_out), 32'h0);
      chk("rst_rd", 32'(mem_rd), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("f1_rd", 32'(mem_rd), 32'h1);
      chk("f1_addr", 32'(mem_addr), 32'h0000);
      idle();
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hA5C3);
      chk("f1_ir", 32'(ir_d), 32'hA5C3);
      chk("f1_ce", 32'(ir_ce), 32'h1);
      chk("f1_done", 32'(fetch_done), 32'h1);
      idle();
      chk("f1_ce_off", 32'(ir_ce), 32'h0);
      chk("f1_pc", 32'(pc_out), 32'h0001);

      // PC wrap from all-ones
      cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0);
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("wrap_addr", 32'(mem_addr), 32'hFFFF);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
      chk("wrap_ir", 32'(ir_d), 32'h1234);
      idle();
      chk("wrap_pc", 32'(pc_out), 32'h0000);

      // Redirect and fetch requested together in IDLE
      cyc(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0);
      chk("sim_addr", 32'(mem_addr), 32'h0040);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF);
      idle();
      chk("sim_pc", 32'(pc_out), 32'h0041);

      // Redirect while the fetch is outstanding
      cyc(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0);
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b1, 16'h0200, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h7777);
      chk("rdr_addr", 32'(mem_addr), 32'h0010);
      chk("rdr_ir", 32'(ir_d), 32'h7777);
      chk("rdr_ce", 32'(ir_ce), 32'h1);
      idle();
      chk("rdr_pc", 32'(pc_out), 32'h0200);

      // Timeout: no ack for 15 wait cycles
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      for (int i = 0; i < 14; i++) idle();
      chk("tmo_rd_held", 32'(mem_rd), 32'h1);
      idle();
      chk("tmo_rd", 32'(mem_rd), 32'h0);
      chk("tmo_err", 32'(fetch_err), 32'h1);
      chk("tmo_ce", 32'(ir_ce), 32'h0);
      chk("tmo_pc", 32'(pc_out), 32'h0200);
      chk("tmo_ir", 32'(ir_d), 32'h7777);
      idle();
      chk("tmo_err_off", 32'(fetch_err), 32'h0);

      // Ack on the last permitted wait cycle succeeds
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      for (int i = 0; i < 14; i++) idle();
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5A5A);
      chk("edge_ce", 32'(ir_ce), 32'h1);
      chk("edge_err", 32'(fetch_err), 32'h0);
      chk("edge_ir", 32'(ir_d), 32'h5A5A);
      idle();
      chk("edge_pc", 32'(pc_out), 32'h0201);

      // Two redirects while busy: the later one wins, including one in LOAD
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
      cyc(1'b0, 1'b0, 1'b1, 16'h0400, 1'b0, 16'h0);
      chk("two_rdr_pc", 32'(pc_out), 32'h0400);

      // Reset mid-fetch, then a stray late ack
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      idle();
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      chk("mid_rst_rd", 32'(mem_rd), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_pc", 32'(pc_out), 32'h0000);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hDEAD);
      chk("late_ack_ce", 32'(ir_ce), 32'h0);
      chk("late_ack_ir", 32'(ir_d), 32'h0000);
      idle();
      idle();

      @(negedge clk);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
